vgroup_sequencer: RTL

Sequences one accepted vector instruction into LMUL per-register micro-ops (uops) for the single-register vector ALU. It sits between vector decode and the ALU/register-file read stage, replacing the stateless group-index stepping with a handshaked, vl-aware sequencer. It tracks remaining active elements and validates register-group alignment. It drives the front-end stall while a group is in flight.

---
 rtl/vgroup_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vgroup_sequencer.sv
//------------------------------------------------------------------------------
// Module  : vgroup_sequencer
// Brief   : Splits one accepted vector instruction into per-register uops,
//           vl-aware, with register-group alignment checking.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vgroup_sequencer #(
  parameter int VLEN = 128,
  parameter int EW   = $clog2(VLEN) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    raA,
  input  logic [4:0]    raB,
  input  logic [4:0]    rdest,
  input  logic [2:0]    lmul_reg,
  input  logic [1:0]    sew,
  input  logic [EW-1:0] vl,
  output logic          uop_valid,
  input  logic          uop_ready,
  output logic [4:0]    uop_raA,
  output logic [4:0]    uop_raB,
  output logic [4:0]    uop_rdest,
  output logic [2:0]    uop_idx,
  output logic [EW-1:0] uop_elems,
  output logic          uop_first,
  output logic          uop_last,
  output logic          stall,
  output logic          done,
  output logic          illegal
);

  localparam int EPR_SEW8 = VLEN / 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    ra_a_q, ra_a_d;
  logic [4:0]    ra_b_q, ra_b_d;
  logic [4:0]    rdest_q, rdest_d;
  logic [2:0]    idx_q, idx_d;
  logic [EW-1:0] rem_q, rem_d;
  logic [EW-1:0] epr_q, epr_d;
  logic          done_q, done_d;
  logic          illegal_q, illegal_d;

  logic [EW-1:0] epr_in;
  logic [EW-1:0] vlmax_in;
  logic [EW-1:0] rem_in;
  logic [4:0]    lmul_mask;
  logic          is_illegal;
  logic          issuing;
  logic          cur_last;
  logic [EW-1:0] cur_elems;

  // VLMAX never exceeds VLEN for legal LMUL, so EW bits hold it exactly.
  assign epr_in     = EW'(EPR_SEW8) >> sew;
  assign vlmax_in   = epr_in << lmul_reg[1:0];
  assign rem_in     = (vl < vlmax_in) ? vl : vlmax_in;
  assign lmul_mask  = (5'd1 << lmul_reg[1:0]) - 5'd1;
  assign is_illegal = lmul_reg[2] | (|((raA | raB | rdest) & lmul_mask));

  assign issuing    = (state_q == ISSUE);
  assign cur_last   = (rem_q <= epr_q);
  assign cur_elems  = cur_last ? rem_q : epr_q;

  always_comb begin
    state_d   = state_q;
    ra_a_d    = ra_a_q;
    ra_b_d    = ra_b_q;
    rdest_d   = rdest_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    epr_d     = epr_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_illegal) begin
            illegal_d = 1'b1;
          end else if (vl == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
            ra_a_d  = raA;
            ra_b_d  = raB;
            rdest_d = rdest;
            idx_d   = 3'd0;
            rem_d   = rem_in;
            epr_d   = epr_in;
          end
        end
      end
      ISSUE: begin
        if (uop_ready) begin
          idx_d = idx_q + 3'd1;
          rem_d = rem_q - cur_elems;
          if (cur_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ra_a_q    <= '0;
      ra_b_q    <= '0;
      rdest_q   <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      epr_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ra_a_q    <= ra_a_d;
      ra_b_q    <= ra_b_d;
      rdest_q   <= rdest_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      epr_q     <= epr_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Uop fields read as zero whenever no group is in flight.
  assign uop_valid = issuing;
  assign uop_raA   = issuing ? (ra_a_q + 5'(idx_q)) : 5'd0;
  assign uop_raB   = issuing ? (ra_b_q + 5'(idx_q)) : 5'd0;
  assign uop_rdest = issuing ? (rdest_q + 5'(idx_q)) : 5'd0;
  assign uop_idx   = issuing ? idx_q : 3'd0;
  assign uop_elems = issuing ? cur_elems : '0;
  assign uop_first = issuing & (idx_q == 3'd0);
  assign uop_last  = issuing & cur_last;
  assign stall     = issuing;
  assign in_ready  = ~issuing;
  assign done      = done_q;
  assign illegal   = illegal_q;

endmodule

`default_nettype wire
